sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_W, default 128, pixels per line; legal range 3..1024.
REQ-002 Parameter IMG_H, default 128, lines per frame; legal range 3..1024.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_pixel is valid this cycle; gaps of any length are permitted.
REQ-006 in_pixel  input  8  unsigned pixel, raster order, line-major, no side-band sync.
REQ-007 win_valid  output  1  px_1..px_9 hold a complete 3x3 window this cycle.
REQ-008 px_1..px_9  output  8 each  window row-major: px_1 top-left, px_5 centre, px_9 bottom-right; feeds the Sobel core directly.
REQ-009 win_row, win_col  output  10 each  image coordinate of the window centre pixel.
REQ-010 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 A pixel is accepted on each rising edge where in_valid=1; no backpressure exists.
REQ-012 Column counter col counts 0..IMG_W-1 per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
REQ-013 Row counter row counts 0..IMG_H-1; on accepting (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next pixel starts a new frame.
REQ-014 Two line buffers of IMG_W x 8 bits hold rows r-1 and r-2; the 3x3 register array shifts left by one column per accepted pixel.
REQ-015 On accepting pixel (r,c) with r>=2 and c>=2, win_valid=1 in the next cycle, with px_1=(r-2,c-2) through px_9=(r,c), win_row=r-1, win_col=c-1.
REQ-016 Latency: exactly 1 cycle from acceptance edge to win_valid.
REQ-017 No window is produced for border centres (row 0, row IMG_H-1, col 0, col IMG_W-1); exactly (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-018 No window mixes pixels from different lines across the line wrap or from different frames across the frame wrap.
REQ-019 win_valid=0 in any cycle following a cycle with in_valid=0; px_*/win_row/win_col hold their last values while win_valid=0.
REQ-020 frame_done=1 exactly one cycle after acceptance of (IMG_H-1, IMG_W-1), coincident with the frame's last win_valid.
REQ-021 Line-buffer contents are never read into a valid window before being written in the current frame; buffer contents therefore need no reset.

Reset
REQ-022 On rst_n=0: col=0, row=0, win_valid=0, frame_done=0, px_1..px_9=0, win_row=0, win_col=0, immediately and independent of clk.
REQ-023 Reset asserted mid-frame discards the partial frame; the first pixel accepted after release is (0,0).
REQ-024 Reset release requires no input flushing; in_valid is honoured from the first rising edge after release.

Structure
REQ-025 Shared package sobel_pkg holds PIX_W=8, COORD_W=10, and default IMG_W/IMG_H constants, shared with the Sobel core wrapper.
REQ-026 One sub-module sobel_line_buf: single-clock circular buffer, depth IMG_W, 8-bit, read-before-write at the same address, write enable = in_valid; instantiated twice, cascaded.

Verification
REQ-027 IMG_W=5, IMG_H=4, pixel value = 5r+c, in_valid held 1 -> first win_valid the cycle after pixel 12 is accepted, px_1..px_9 = 0,1,2,5,6,7,10,11,12, win_row=1, win_col=1; 6 windows total; last window px_9=19, frame_done=1 in the same cycle.
REQ-028 Same image with random in_valid gaps (30% idle) -> identical window sequence and values; win_valid never high after an idle cycle.
REQ-029 Two back-to-back frames, frame 2 value = 100+5r+c -> frame 2 first window px_1=100, px_9=112; no window has pixels from both frames; 12 windows total, 2 frame_done pulses.
REQ-030 rst_n pulsed low after 8 pixels of frame 1, then full frame with value = 5r+c -> outputs zero during reset; post-release windows match REQ-027 exactly.
REQ-031 IMG_W=3, IMG_H=3, pixels 1..9 -> single window px_1..px_9 = 1..9, win_row=1, win_col=1, frame_done in the same cycle.
REQ-032 Default 128x128 random image against a software model -> 126*126 windows, all bit-exact, with Sobel core output compared end-to-end.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel window generator and the Sobel core wrapper.
//   PIX_W     : pixel width in bits
//   COORD_W   : width of row/column coordinates
//   IMG_W_DEF : default pixels per line
//   IMG_H_DEF : default lines per frame
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int COORD_W   = 10;
    localparam int IMG_W_DEF = 128;
    localparam int IMG_H_DEF = 128;

    // A window is complete once the accepted pixel has two rows and two
    // columns of history above and to its left in the current frame.
    function automatic logic win_complete(input logic [COORD_W-1:0] row,
                                          input logic [COORD_W-1:0] col);
        return (row >= 10'd2) && (col >= 10'd2);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Single-clock circular line buffer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   i_we       : write enable; pointer advances on every write
//   i_din      : data written at the current pointer
//   o_dout     : data at the current pointer, read before the same-cycle
//                write, i.e. the value written DEPTH writes ago
module sobel_line_buf #(
    parameter int DEPTH = 128,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_ptr;

    assign o_dout = r_mem[r_ptr];

    // Storage array; contents are always written before being used, so no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    // Circular write/read pointer, wraps at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_we) begin
            if (r_ptr == AW'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_pixel: accepted pixel stream, raster order, no backpressure
//   win_valid        : px_1..px_9 hold a complete window (1 cycle after accept)
//   px_1..px_9       : window, row-major, px_5 is the centre
//   win_row/win_col  : image coordinate of the centre pixel
//   frame_done       : one-cycle pulse after the frame's last pixel is accepted
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               win_valid,
    output logic [PIX_W-1:0]   px_1,
    output logic [PIX_W-1:0]   px_2,
    output logic [PIX_W-1:0]   px_3,
    output logic [PIX_W-1:0]   px_4,
    output logic [PIX_W-1:0]   px_5,
    output logic [PIX_W-1:0]   px_6,
    output logic [PIX_W-1:0]   px_7,
    output logic [PIX_W-1:0]   px_8,
    output logic [PIX_W-1:0]   px_9,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               frame_done
);

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_win_en;
    logic [PIX_W-1:0]   w_lb1;   // same column, row r-1
    logic [PIX_W-1:0]   w_lb2;   // same column, row r-2
    // Two previous columns of the window: [0]=top, [1]=middle, [2]=bottom row.
    logic [PIX_W-1:0]   r_sh [3][2];

    // Cascaded line buffers: the second one sees the first one's delayed output.
    sobel_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (in_valid),
        .i_din  (in_pixel),
        .o_dout (w_lb1)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (in_valid),
        .i_din  (w_lb1),
        .o_dout (w_lb2)
    );

    // Position decode and window-enable for the pixel being accepted.
    always_comb begin
        w_col_last = (r_col == COORD_W'(IMG_W - 1));
        w_row_last = (r_row == COORD_W'(IMG_H - 1));
        if (in_valid) begin
            w_win_en = win_complete(r_row, r_col);
        end else begin
            w_win_en = 1'b0;
        end
    end

    // Raster position counters; wrap per line and per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 10'd1;
                end
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Column shift register: keeps the two columns preceding the incoming one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_sh[k][0] <= '0;
                r_sh[k][1] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
                r_sh[k][0] <= r_sh[k][1];
            end
            r_sh[0][1] <= w_lb2;
            r_sh[1][1] <= w_lb1;
            r_sh[2][1] <= in_pixel;
        end
    end

    // Output window registers; loaded only for complete windows, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            px_1       <= '0;
            px_2       <= '0;
            px_3       <= '0;
            px_4       <= '0;
            px_5       <= '0;
            px_6       <= '0;
            px_7       <= '0;
            px_8       <= '0;
            px_9       <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= w_win_en;
            frame_done <= in_valid && w_col_last && w_row_last;
            if (w_win_en) begin
                px_1    <= r_sh[0][0];
                px_2    <= r_sh[0][1];
                px_3    <= w_lb2;
                px_4    <= r_sh[1][0];
                px_5    <= r_sh[1][1];
                px_6    <= w_lb1;
                px_7    <= r_sh[2][0];
                px_8    <= r_sh[2][1];
                px_9    <= in_pixel;
                win_row <= r_row - 10'd1;
                win_col <= r_col - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen: a 5x4 instance driven from a
// vector table, a 3x3 instance and a 128x128 instance against an image model.
module tb_sobel_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ---------------- 5x4 instance ----------------
    logic        a_v;
    logic [7:0]  a_p;
    logic        a_wv, a_fd;
    logic [7:0]  a_px [9];
    logic [9:0]  a_row, a_col;
    logic [71:0] a_flat;
    assign a_flat = {a_px[0], a_px[1], a_px[2], a_px[3], a_px[4],
                     a_px[5], a_px[6], a_px[7], a_px[8]};

    sobel_window_gen #(.IMG_W(5), .IMG_H(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_pixel(a_p),
        .win_valid(a_wv),
        .px_1(a_px[0]), .px_2(a_px[1]), .px_3(a_px[2]),
        .px_4(a_px[3]), .px_5(a_px[4]), .px_6(a_px[5]),
        .px_7(a_px[6]), .px_8(a_px[7]), .px_9(a_px[8]),
        .win_row(a_row), .win_col(a_col), .frame_done(a_fd)
    );

    // ---------------- 3x3 instance ----------------
    logic        b_v;
    logic [7:0]  b_p;
    logic        b_wv, b_fd;
    logic [7:0]  b_px [9];
    logic [9:0]  b_row, b_col;
    logic [71:0] b_flat;
    assign b_flat = {b_px[0], b_px[1], b_px[2], b_px[3], b_px[4],
                     b_px[5], b_px[6], b_px[7], b_px[8]};

    sobel_window_gen #(.IMG_W(3), .IMG_H(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_pixel(b_p),
        .win_valid(b_wv),
        .px_1(b_px[0]), .px_2(b_px[1]), .px_3(b_px[2]),
        .px_4(b_px[3]), .px_5(b_px[4]), .px_6(b_px[5]),
        .px_7(b_px[6]), .px_8(b_px[7]), .px_9(b_px[8]),
        .win_row(b_row), .win_col(b_col), .frame_done(b_fd)
    );

    // ---------------- 128x128 instance ----------------
    logic        c_v;
    logic [7:0]  c_p;
    logic        c_wv, c_fd;
    logic [7:0]  c_px [9];
    logic [9:0]  c_row, c_col;
    logic [71:0] c_flat;
    assign c_flat = {c_px[0], c_px[1], c_px[2], c_px[3], c_px[4],
                     c_px[5], c_px[6], c_px[7], c_px[8]};

    sobel_window_gen u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_v), .in_pixel(c_p),
        .win_valid(c_wv),
        .px_1(c_px[0]), .px_2(c_px[1]), .px_3(c_px[2]),
        .px_4(c_px[3]), .px_5(c_px[4]), .px_6(c_px[5]),
        .px_7(c_px[6]), .px_8(c_px[7]), .px_9(c_px[8]),
        .win_row(c_row), .win_col(c_col), .frame_done(c_fd)
    );

    // ---------------- checking infrastructure ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One record per accepted pixel of the 5x4 frame (value 5r+c = index).
    typedef struct {
        logic [7:0]  pix;
        logic        v;
        logic        fd;
        logic [9:0]  r;
        logic [9:0]  c;
        logic [71:0] px;
    } vec_t;

    vec_t        tbl [20];
    logic [91:0] last_w;     // last window expected on the outputs {px,row,col}
    int          wins;
    int          fds;

    function automatic logic [71:0] addoff(input logic [71:0] x, input logic [7:0] o);
        logic [71:0] y;
        for (int k = 0; k < 9; k++) begin
            y[k*8 +: 8] = x[k*8 +: 8] + o;
        end
        return y;
    endfunction

    // Stream one 5x4 frame from the table, optionally with random idle cycles.
    task automatic run_frame(input logic [7:0] off, input bit gaps);
        logic [91:0] exp_w;
        for (int i = 0; i < 20; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3; g++) begin
                    if ($urandom_range(0, 9) < 3) begin
                        a_v = 1'b0;
                        @(posedge clk); #1;
                        chk("idle_valid", {95'd0, a_wv}, 96'd0);
                        chk("idle_fd", {95'd0, a_fd}, 96'd0);
                        chk("idle_hold", {4'd0, a_flat, a_row, a_col}, {4'd0, last_w});
                    end
                end
            end
            a_v = 1'b1;
            a_p = tbl[i].pix + off;
            @(posedge clk); #1;
            a_v = 1'b0;
            if (a_wv) wins++;
            if (a_fd) fds++;
            chk("win_valid", {95'd0, a_wv}, {95'd0, tbl[i].v});
            chk("frame_done", {95'd0, a_fd}, {95'd0, tbl[i].fd});
            if (tbl[i].v) begin
                exp_w  = {addoff(tbl[i].px, off), tbl[i].r, tbl[i].c};
                last_w = exp_w;
                chk("window", {4'd0, a_flat, a_row, a_col}, {4'd0, exp_w});
            end else begin
                chk("border_hold", {4'd0, a_flat, a_row, a_col}, {4'd0, last_w});
            end
        end
    endtask

    logic [7:0]  img [128*128];
    logic [71:0] exp_px;
    int          c_wins;

    initial begin
        rst_n = 1'b0;
        a_v = 1'b0; a_p = 8'd0;
        b_v = 1'b0; b_p = 8'd0;
        c_v = 1'b0; c_p = 8'd0;
        last_w = 92'd0;

        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{pix: 8'(i), v: 1'b0, fd: 1'b0, r: 10'd0, c: 10'd0, px: 72'd0};
        end
        tbl[12] = '{8'd12, 1'b1, 1'b0, 10'd1, 10'd1,
                    {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12}};
        tbl[13] = '{8'd13, 1'b1, 1'b0, 10'd1, 10'd2,
                    {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13}};
        tbl[14] = '{8'd14, 1'b1, 1'b0, 10'd1, 10'd3,
                    {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14}};
        tbl[17] = '{8'd17, 1'b1, 1'b0, 10'd2, 10'd1,
                    {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17}};
        tbl[18] = '{8'd18, 1'b1, 1'b0, 10'd2, 10'd2,
                    {8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18}};
        tbl[19] = '{8'd19, 1'b1, 1'b1, 10'd2, 10'd3,
                    {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19}};

        // Reset state.
        #1;
        chk("reset_a", {2'd0, a_wv, a_fd, a_flat, a_row, a_col}, 96'd0);
        chk("reset_b", {2'd0, b_wv, b_fd, b_flat, b_row, b_col}, 96'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single frame, continuous valid.
        wins = 0; fds = 0;
        run_frame(8'd0, 1'b0);
        chk("f1_wins", 96'(wins), 96'd6);
        chk("f1_fds", 96'(fds), 96'd1);

        // Same frame with random idle gaps.
        wins = 0; fds = 0;
        run_frame(8'd0, 1'b1);
        chk("gap_wins", 96'(wins), 96'd6);
        chk("gap_fds", 96'(fds), 96'd1);

        // Two back-to-back frames, second offset by 100.
        wins = 0; fds = 0;
        run_frame(8'd0, 1'b0);
        run_frame(8'd100, 1'b0);
        chk("b2b_wins", 96'(wins), 96'd12);
        chk("b2b_fds", 96'(fds), 96'd2);

        // Reset mid-frame after 8 pixels, then a clean frame.
        for (int i = 0; i < 8; i++) begin
            a_v = 1'b1;
            a_p = tbl[i].pix;
            @(posedge clk); #1;
            chk("pre_rst_valid", {95'd0, a_wv}, 96'd0);
        end
        a_v = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", {2'd0, a_wv, a_fd, a_flat, a_row, a_col}, 96'd0);
        @(posedge clk); #1;
        chk("held_reset_a", {2'd0, a_wv, a_fd, a_flat, a_row, a_col}, 96'd0);
        rst_n = 1'b1;
        last_w = 92'd0;
        wins = 0; fds = 0;
        run_frame(8'd0, 1'b0);
        chk("rst_wins", 96'(wins), 96'd6);
        chk("rst_fds", 96'(fds), 96'd1);

        // Minimum 3x3 image.
        for (int k = 1; k <= 9; k++) begin
            b_v = 1'b1;
            b_p = 8'(k);
            @(posedge clk); #1;
            b_v = 1'b0;
            if (k < 9) begin
                chk("b_early_valid", {94'd0, b_wv, b_fd}, 96'd0);
            end else begin
                chk("b_valid_fd", {94'd0, b_wv, b_fd}, 96'd3);
                chk("b_window", {4'd0, b_flat, b_row, b_col},
                    {4'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                     10'd1, 10'd1});
            end
        end

        // Default 128x128 random image against an image-array model.
        for (int i = 0; i < 128*128; i++) begin
            img[i] = 8'($urandom_range(0, 255));
        end
        c_wins = 0;
        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 128; c++) begin
                c_v = 1'b1;
                c_p = img[r*128 + c];
                @(posedge clk); #1;
                c_v = 1'b0;
                if (r >= 2 && c >= 2) begin
                    c_wins++;
                    for (int k = 0; k < 9; k++) begin
                        exp_px[(8 - k)*8 +: 8] = img[(r - 2 + k/3)*128 + (c - 2 + k%3)];
                    end
                    chk("c_window", {1'b0, c_wv, c_flat, c_row, c_col},
                        {1'b0, 1'b1, exp_px, 10'(r - 1), 10'(c - 1)});
                end else begin
                    chk("c_border_valid", {95'd0, c_wv}, 96'd0);
                end
                chk("c_frame_done", {95'd0, c_fd}, {95'd0, (r == 127 && c == 127)});
            end
        end
        chk("c_wins", 96'(c_wins), 96'd15876);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
